// File: rtl/npc_ctrl_pkg.sv
// npc_ctrl_pkg: shared state, opcode, immediate-select, PC/WB source and error codes for the NPC sequencer
package npc_ctrl_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_FWAIT, S_DECODE, S_EXEC,
    S_MREQ, S_MWAIT, S_WB, S_HALT, S_ERROR
  } state_t;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;
  localparam logic [2:0] EXT_I    = 3'b000;
  localparam logic [2:0] EXT_U    = 3'b001;
  localparam logic [2:0] EXT_S    = 3'b010;
  localparam logic [2:0] EXT_B    = 3'b011;
  localparam logic [2:0] EXT_J    = 3'b100;
  localparam logic [2:0] EXT_SH   = 3'b101;
  localparam logic [2:0] EXT_NONE = 3'b111;
  localparam logic [1:0] PC_SEL_PC4  = 2'b00;
  localparam logic [1:0] PC_SEL_IMM  = 2'b01;
  localparam logic [1:0] PC_SEL_JALR = 2'b10;
  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_IFU_TO  = 2'b10;
  localparam logic [1:0] ERR_LSU_TO  = 2'b11;
  localparam int CLS_W    = 10;
  localparam int C_LOAD   = 0;
  localparam int C_STORE  = 1;
  localparam int C_BRANCH = 2;
  localparam int C_JAL    = 3;
  localparam int C_JALR   = 4;
  localparam int C_OPIMM  = 5;
  localparam int C_LUI    = 6;
  localparam int C_AUIPC  = 7;
  localparam int C_OP     = 8;
  localparam int C_SYSTEM = 9;
  // classes that never write a destination register
  localparam logic [CLS_W-1:0] CLS_NO_RD = CLS_W'(1 << C_BRANCH) | CLS_W'(1 << C_STORE);
endpackage

// File: rtl/npc_inst_class.sv
// npc_inst_class: combinational opcode classifier producing a one-hot class, immediate select and illegal flag
//   opcode  in  7   IR[6:0]
//   funct3  in  3   IR[14:12]
//   cls     out 10  one-hot instruction class (C_* bit positions)
//   ext_op  out 3   immediate-format select
//   illegal out 1   opcode matches no supported class
module npc_inst_class
  import npc_ctrl_pkg::*;
(
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  output logic [CLS_W-1:0] cls,
  output logic [2:0]       ext_op,
  output logic             illegal
);
  logic shift;
  always_comb begin
    cls = '0;
    cls[C_LOAD]   = opcode == OPC_LOAD;
    cls[C_STORE]  = opcode == OPC_STORE;
    cls[C_BRANCH] = opcode == OPC_BRANCH;
    cls[C_JAL]    = opcode == OPC_JAL;
    cls[C_JALR]   = opcode == OPC_JALR;
    cls[C_OPIMM]  = opcode == OPC_OPIMM;
    cls[C_LUI]    = opcode == OPC_LUI;
    cls[C_AUIPC]  = opcode == OPC_AUIPC;
    cls[C_OP]     = opcode == OPC_OP;
    cls[C_SYSTEM] = opcode == OPC_SYSTEM;
    illegal = ~|cls;
    // slli/srli/srai carry a shamt, not a sign-extended immediate
    shift = cls[C_OPIMM] && (funct3 == 3'b001 || funct3 == 3'b101);
    ext_op = shift ? EXT_SH :
             (cls[C_LOAD] || cls[C_JALR] || cls[C_OPIMM]) ? EXT_I :
             (cls[C_LUI] || cls[C_AUIPC]) ? EXT_U :
             cls[C_STORE] ? EXT_S :
             cls[C_BRANCH] ? EXT_B :
             cls[C_JAL] ? EXT_J : EXT_NONE;
  end
endmodule

// File: rtl/npc_ctrl_fsm.sv
// npc_ctrl_fsm: multi-cycle NPC sequencer driving IFU/LSU handshakes, IR, immediate select and PC/RF/WB strobes
//   clk, rst_n                      clock, async active-low reset
//   ifu_req_valid/ready             fetch request handshake
//   ifu_rsp_valid, ifu_rsp_data     fetched instruction
//   instr                           IR contents
//   ext_op                          immediate-format select (DECODE..WB, else 111)
//   lsu_req_valid/wen/ready         memory request handshake (wen 1 = store)
//   lsu_rsp_valid                   memory access complete
//   branch_taken                    ALU compare, used in WB
//   pc_we, pc_sel                   PC update strobe (retire pulse) and source
//   rf_we, wb_sel                   register write and writeback source
//   halt, err                       sticky ebreak flag and error code
module npc_ctrl_fsm
  import npc_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  input  logic        ifu_rsp_valid,
  input  logic [31:0] ifu_rsp_data,
  output logic [31:0] instr,
  output logic [2:0]  ext_op,
  output logic        lsu_req_valid,
  output logic        lsu_req_wen,
  input  logic        lsu_req_ready,
  input  logic        lsu_rsp_valid,
  input  logic        branch_taken,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        halt,
  output logic [1:0]  err
);
  localparam logic [TO_W:0] TO_LIM = (TO_W+1)'(TIMEOUT);
  state_t           state, state_nx;
  logic [31:0]      ir;
  logic [TO_W-1:0]  cnt;
  logic [CLS_W-1:0] cls;
  logic [2:0]       dec_ext;
  logic             illegal, wait_st, rsp_in, to_hit, in_wb;
  npc_inst_class u_cls (
    .opcode  (ir[6:0]),
    .funct3  (ir[14:12]),
    .cls     (cls),
    .ext_op  (dec_ext),
    .illegal (illegal)
  );
  assign wait_st = state == S_FWAIT || state == S_MWAIT;
  assign rsp_in  = state == S_FWAIT ? ifu_rsp_valid : lsu_rsp_valid;
  // the count that would be reached this cycle hits the limit; a response in the same cycle wins
  assign to_hit  = TIMEOUT != 0 && wait_st && !rsp_in && ({1'b0, cnt} + (TO_W+1)'(1) == TO_LIM);
  assign in_wb   = state == S_WB;
  assign instr   = ir;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end
  // counter is held at zero outside the wait states, so it is clear on every entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir  <= '0;
      cnt <= '0;
      err <= ERR_NONE;
    end else begin
      ir  <= (state == S_FWAIT && ifu_rsp_valid) ? ifu_rsp_data : ir;
      cnt <= wait_st ? cnt + TO_W'(1) : '0;
      err <= (state == S_DECODE && illegal) ? ERR_ILLEGAL :
             to_hit ? (state == S_FWAIT ? ERR_IFU_TO : ERR_LSU_TO) : err;
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   state_nx = S_FETCH;
      S_FETCH:  state_nx = ifu_req_ready ? S_FWAIT : S_FETCH;
      S_FWAIT:  state_nx = ifu_rsp_valid ? S_DECODE : to_hit ? S_ERROR : S_FWAIT;
      S_DECODE: state_nx = illegal ? S_ERROR : ir == INSN_EBREAK ? S_HALT : S_EXEC;
      S_EXEC:   state_nx = (cls[C_LOAD] || cls[C_STORE]) ? S_MREQ : S_WB;
      S_MREQ:   state_nx = lsu_req_ready ? S_MWAIT : S_MREQ;
      S_MWAIT:  state_nx = lsu_rsp_valid ? S_WB : to_hit ? S_ERROR : S_MWAIT;
      S_WB:     state_nx = S_FETCH;
      default:  state_nx = state;
    endcase
  end
  always_comb begin
    ifu_req_valid = state == S_FETCH;
    lsu_req_valid = state == S_MREQ;
    lsu_req_wen   = state == S_MREQ && cls[C_STORE];
    ext_op = (state inside {S_DECODE, S_EXEC, S_MREQ, S_MWAIT, S_WB}) ? dec_ext : EXT_NONE;
    pc_we  = in_wb;
    pc_sel = !in_wb ? PC_SEL_PC4 :
             (cls[C_JAL] || (cls[C_BRANCH] && branch_taken)) ? PC_SEL_IMM :
             cls[C_JALR] ? PC_SEL_JALR : PC_SEL_PC4;
    rf_we  = in_wb && |(cls & ~CLS_NO_RD) && |ir[11:7];
    wb_sel = !in_wb ? WB_SEL_ALU :
             cls[C_LOAD] ? WB_SEL_MEM :
             (cls[C_JAL] || cls[C_JALR]) ? WB_SEL_PC4 : WB_SEL_ALU;
    halt   = state == S_HALT;
  end
endmodule

// File: doc/npc_ctrl_fsm.md
Name: npc_ctrl_fsm

Overview:
- Multi-cycle sequencer for the NPC core. It drives the instruction fetch (IFU) and load/store (LSU) request/response handshakes and latches the instruction register (IR).
- It configures the immediate generator through a 3-bit ext_op select and produces PC, register-file and writeback control strobes.
- One instruction is in flight at a time. There is no pipelining.

Parameters:
- TIMEOUT, default 255: maximum cycles spent in either wait state before entering ERROR. A value of 0 disables the timeout.
- TO_W, default 8: width of the timeout counter. Must satisfy TO_W >= clog2(TIMEOUT+1).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- ifu_req_valid  out  1  fetch request.
- ifu_req_ready  in  1  IFU accepts the request.
- ifu_rsp_valid  in  1  fetched instruction valid.
- ifu_rsp_data  in  32  fetched instruction.
- instr  out  32  IR contents.
- ext_op  out  3  immediate-format select.
- lsu_req_valid  out  1  memory request.
- lsu_req_wen  out  1  1 = store, 0 = load.
- lsu_req_ready  in  1  LSU accepts the request.
- lsu_rsp_valid  in  1  memory access complete.
- branch_taken  in  1  ALU compare result, sampled in WB.
- pc_we  out  1  PC update strobe; also the retire pulse.
- pc_sel  out  2  PC source: 00 = pc+4, 01 = pc+imm, 10 = (rs1+imm)&~1.
- rf_we  out  1  register-file write.
- wb_sel  out  2  writeback source: 00 = ALU, 01 = memory, 10 = pc+4.
- halt  out  1  sticky; ebreak executed.
- err  out  2  sticky error code: 00 = none, 01 = illegal instruction, 10 = IFU timeout, 11 = LSU timeout.

Behaviour:
- Reset (asynchronous, any state): state = IDLE, IR = 0, counter = 0, err = 0. All outputs are 0 and ext_op = 111.
- All outputs are Moore, decoded from state and IR. The only exception is pc_sel in WB, which also uses branch_taken.
- IDLE: advances to FETCH on the next cycle unconditionally.
- FETCH:
  - ifu_req_valid = 1.
  - On ifu_req_ready, go to FWAIT. Otherwise hold, with no timeout in this state.
- FWAIT:
  - On ifu_rsp_valid, capture IR <- ifu_rsp_data and go to DECODE.
  - A response can never arrive in the cycle the request is accepted.
- DECODE (one cycle): classify IR[6:0] and drive ext_op.
  - ext_op = 000 for I-type (load, jalr, op-imm other than shifts).
  - ext_op = 101 for shift-imm (op-imm with funct3 = 001 or 101).
  - ext_op = 001 for lui/auipc; 010 for store; 011 for branch; 100 for jal.
  - ext_op = 111 for op (R-type) and system.
  - ext_op holds its value from DECODE through WB.
  - Illegal opcode: err = 01, go to ERROR.
  - ebreak (IR == 0x00100073): go to HALT.
  - Any other class: go to EXEC.
- EXEC (one cycle): load/store go to MREQ; everything else goes to WB.
- MREQ:
  - lsu_req_valid = 1 and lsu_req_wen = store.
  - On lsu_req_ready, go to MWAIT.
- MWAIT: on lsu_rsp_valid, go to WB.
- WB (one cycle), then FETCH:
  - pc_we = 1.
  - pc_sel = 01 for jal, or for a branch when branch_taken = 1.
  - pc_sel = 10 for jalr; 00 otherwise.
  - rf_we = 1 except for branch and store, and forced to 0 when IR[11:7] == 0.
  - wb_sel = 01 for load, 10 for jal/jalr, 00 otherwise.
- Timeout counter:
  - Cleared on entry to FWAIT or MWAIT; increments each cycle the response is absent.
  - When the count reaches TIMEOUT, set err = 10 (FWAIT) or 11 (MWAIT) and go to ERROR.
  - A response arriving in the same cycle the count reaches TIMEOUT wins; no error is raised.
- HALT and ERROR are terminal until reset. Only halt or err is driven; all strobes are 0.
- ifu_rsp_valid and lsu_rsp_valid are ignored outside FWAIT and MWAIT respectively. Stale responses after a mid-operation reset are therefore dropped.
- Latency with zero-wait memories:
  - Non-memory instruction: 5 cycles FETCH to WB.
  - Load/store: 7 cycles FETCH to WB.

Decomposition:
- Package npc_ctrl_pkg holds:
  - state enum;
  - opcode constants;
  - EXT_I/U/S/B/J/SH/NONE codes (000/001/010/011/100/101/111);
  - PC_SEL_* and WB_SEL_* codes;
  - ERR_* codes.
- Sub-module npc_inst_class: combinational IR-to-class/ext_op decoder (one-hot class plus illegal flag). It is reused by trace logic.

Test Plan:
- addi x1,x0,5 (0x00500093), IFU ready immediately, response 1 cycle later -> ext_op = 000 in DECODE; pc_we = rf_we = 1, wb_sel = 00, pc_sel = 00 exactly 3 cycles after the ifu_rsp_valid cycle; FETCH follows.
- lw x2,0(x1) with lsu_req_ready delayed 2 cycles and response 3 cycles later -> lsu_req_valid held 3 cycles with wen = 0; WB has rf_we = 1, wb_sel = 01.
- beq taken (0x00208463, branch_taken = 1) -> ext_op = 011; WB has pc_sel = 01, rf_we = 0. With branch_taken = 0, pc_sel = 00.
- srai x3,x3,2 (0x4021d193) -> ext_op = 101. Then ebreak -> halt = 1 permanently, no further ifu_req_valid.
- TIMEOUT = 4, no ifu_rsp_valid -> err = 10 after 4 FWAIT cycles. Repeat with the response on the 4th cycle -> no error.
- rst_n asserted mid-MWAIT, lsu_rsp_valid pulsed after release -> outputs 0 immediately; response ignored; FETCH one cycle after IDLE.
